// File: rtl/uart_mem_dump.sv
// rtl/uart_mem_dump.sv - streams a word-addressed memory range out of a UART, 4 bytes per word LSB first
module uart_mem_dump #(
   parameter int BAUD_DIV = 87,
   parameter int ADDR_W   = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_dout,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE, READ, CAPTURE, START_BIT, DATA_BITS, STOP_BIT, NEXT
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     baud_cnt;
   logic [2:0]        bit_idx;
   logic [1:0]        byte_idx;
   logic [ADDR_W-1:0] addr, last_addr;
   logic [31:0]       shift;
   logic              baud_end, last_word;

   assign baud_end  = (baud_cnt == CW'(BAUD_DIV - 1));
   assign last_word = (addr == last_addr);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start && !(end_addr < start_addr)) state_nxt = READ;
         READ:      state_nxt = CAPTURE;
         CAPTURE:   state_nxt = START_BIT;
         START_BIT: if (baud_end) state_nxt = DATA_BITS;
         DATA_BITS: if (baud_end && bit_idx == 3'd7) state_nxt = STOP_BIT;
         STOP_BIT:  if (baud_end) state_nxt = (byte_idx == 2'd3) ? NEXT : START_BIT;
         NEXT:      state_nxt = last_word ? IDLE : READ;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         addr      <= '0;
         last_addr <= '0;
         shift     <= '0;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         byte_idx  <= '0;
      end else begin
         state  <= state_nxt;
         mem_rd <= (state_nxt == READ);
         done   <= 1'b0;
         if (state inside {START_BIT, DATA_BITS, STOP_BIT} && !baud_end)
            baud_cnt <= baud_cnt + 1'b1;
         else
            baud_cnt <= '0;
         // tx is loaded with the level of the bit that the next state transmits
         case (state)
            IDLE: if (start) begin
               addr      <= start_addr;
               last_addr <= end_addr;
               if (end_addr < start_addr) begin
                  done <= 1'b1;
               end else begin
                  busy     <= 1'b1;
                  mem_addr <= start_addr;
               end
            end
            CAPTURE: begin
               shift <= mem_dout;
               tx    <= 1'b0;
            end
            START_BIT: if (baud_end) tx <= shift[0];
            DATA_BITS: if (baud_end) begin
               shift   <= shift >> 1;
               bit_idx <= bit_idx + 1'b1;
               tx      <= (bit_idx == 3'd7) ? 1'b1 : shift[1];
            end
            STOP_BIT: if (baud_end) begin
               byte_idx <= byte_idx + 1'b1;
               tx       <= (byte_idx == 2'd3);
            end
            NEXT: if (last_word) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               addr     <= addr + 1'b1;
               mem_addr <= addr + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mem_dump.sv
// tb/tb_uart_mem_dump.sv - scoreboard bench for uart_mem_dump with BAUD_DIV=4
module tb_uart_mem_dump;
   localparam int B  = 4;
   localparam int AW = 14;
   localparam int WORD_CYC = 40 * B + 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW-1:0] end_addr = '0;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_dout = '0;
   logic          tx, busy, done;

   int total = 0;
   int bad = 0;
   logic [AW-1:0] exp_addr[$];
   logic [7:0]    exp_byte[$];

   uart_mem_dump #(.BAUD_DIV(B), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
      .end_addr(end_addr), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_dout(mem_dout), .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input int a);
      if (a == 5) return 32'h12345678;
      return ((a + 1) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   always @(posedge clk) if (mem_rd) mem_dout <= memf(int'(mem_addr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // memory read monitor
   always @(negedge clk) begin
      if (reset && mem_rd === 1'b1) begin
         chk("rd_expected", exp_addr.size() > 0, 1);
         if (exp_addr.size() > 0) chk("rd_addr", mem_addr, exp_addr.pop_front());
      end
   end

   // UART receiver sampling each bit at its midpoint
   bit         rx_on = 0;
   int         ph;
   int         k;
   logic [7:0] rx_b;
   always @(negedge clk) begin
      if (!reset) rx_on = 0;
      else if (!rx_on) begin
         if (tx === 1'b0) begin rx_on = 1; ph = 0; end
      end else begin
         ph++;
         if (ph % B == B / 2) begin
            k = ph / B;
            if (k == 0) chk("start_bit", tx, 0);
            else if (k <= 8) rx_b[k-1] = tx;
            else begin
               chk("stop_bit", tx, 1);
               chk("rx_expected", exp_byte.size() > 0, 1);
               if (exp_byte.size() > 0) chk("rx_byte", rx_b, exp_byte.pop_front());
               rx_on = 0;
            end
         end
      end
   end

   task automatic expect_words(input int sa, input int ea);
      for (int a = sa; a <= ea; a++) begin
         logic [31:0] w;
         w = memf(a);
         exp_addr.push_back(a[AW-1:0]);
         for (int j = 0; j < 4; j++) exp_byte.push_back(w[8*j +: 8]);
      end
   endtask

   task automatic do_start(input int sa, input int ea);
      start_addr = sa[AW-1:0];
      end_addr   = ea[AW-1:0];
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int words, input int k0, input string tag);
      int n;
      int busy_low;
      n = k0;
      busy_low = 0;
      while (done !== 1'b1 && n < words * WORD_CYC + 100) begin
         @(negedge clk);
         n++;
         if (done !== 1'b1 && busy !== 1'b1) busy_low++;
      end
      chk({tag, "_len"}, n, words * WORD_CYC);
      chk({tag, "_busy_held"}, busy_low, 0);
      chk({tag, "_busy_drop"}, busy, 0);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, done, 0);
   endtask

   task automatic run_dump(input int sa, input int ea, input string tag);
      expect_words(sa, ea);
      do_start(sa, ea);
      chk({tag, "_busy_rise"}, busy, 1);
      wait_done(ea - sa + 1, 0, tag);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_addr", mem_addr, 0);

      // start asserted together with reset release
      reset = 1'b1;
      run_dump(5, 5, "single");
      chk("single_drained", exp_byte.size(), 0);

      run_dump(2, 4, "range");
      chk("range_drained", exp_byte.size(), 0);

      do_start(7, 3);
      chk("empty_done", done, 1);
      chk("empty_busy", busy, 0);
      chk("empty_tx", tx, 1);
      chk("empty_rd", mem_rd, 0);
      @(negedge clk);
      chk("empty_done_1cyc", done, 0);
      chk("empty_busy_after", busy, 0);

      expect_words(0, 1);
      do_start(0, 1);
      repeat (50) @(negedge clk);
      do_start(10, 12);
      wait_done(2, 51, "restart_ignored");

      expect_words(8, 8);
      do_start(8, 8);
      repeat (95) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_tx", tx, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_rd", mem_rd, 0);
      chk("midrst_bytes_left", exp_byte.size(), 2);
      exp_byte.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_no_done", done, 0);
      end
      reset = 1'b1;
      run_dump(8, 8, "after_rst");

      run_dump(16383, 16383, "top_addr");
      repeat (20) @(negedge clk);
      chk("top_addr_hold", mem_addr, 16383);
      chk("top_idle_busy", busy, 0);
      chk("top_idle_tx", tx, 1);

      chk("addr_queue_empty", exp_addr.size(), 0);
      chk("byte_queue_empty", exp_byte.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
